systolic_ctrl: RTL and testbench

Sequencing controller for the standard systolic array: a weight-stationary grid of ROWS x COLS PEs built from enable-gated registers. On a start request it does three things. First, it loads one weight row per cycle. Second, it streams a programmed number of input vectors with the per-row diagonal skew. Third, it drains the array and reports completion with a one-cycle done pulse. It owns every write enable and valid strobe the array and its input/output buffers need, so the array itself carries no control logic.

---
 rtl/systolic_ctrl.sv | 128 ++++++++++++
 tb/tb_systolic_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// Sequencer for a weight-stationary systolic array.
// Weight load, skewed input streaming and drain, with a done pulse.
module systolic_ctrl #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int K_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [K_WIDTH-1:0] num_vec,
    input  logic               hold,
    output logic [ROWS-1:0]    wgt_wen,
    output logic               pe_en,
    output logic [ROWS-1:0]    in_valid,
    output logic [K_WIDTH-1:0] in_idx,
    output logic [COLS-1:0]    out_valid,
    output logic               busy,
    output logic               done
);

    localparam int L  = ROWS + COLS - 1;
    localparam int PW = $clog2(ROWS + COLS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        FIN
    } state_t;

    state_t             state, state_d;
    logic [PW-1:0]      ph, ph_d;
    logic [K_WIDTH-1:0] idx, idx_d;
    logic [K_WIDTH-1:0] nv, nv_d;
    logic [L-1:0]       sk;
    logic               streaming;

    assign streaming = (state == STREAM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ph    <= '0;
            idx   <= '0;
            nv    <= '0;
            sk    <= '0;
        end else begin
            state <= state_d;
            ph    <= ph_d;
            idx   <= idx_d;
            nv    <= nv_d;
            // One hop per PE register stage; frozen while held.
            if (!hold) begin
                sk <= {sk[L-2:0], streaming};
            end
        end
    end

    always_comb begin
        state_d = state;
        ph_d    = ph;
        idx_d   = idx;
        nv_d    = nv;
        if (!hold) begin
            unique case (state)
                IDLE: begin
                    if (start && (num_vec != '0)) begin
                        state_d = LOAD;
                        nv_d    = num_vec;
                        ph_d    = '0;
                    end
                end
                LOAD: begin
                    if (ph == PW'(ROWS - 1)) begin
                        state_d = STREAM;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph + PW'(1);
                    end
                end
                STREAM: begin
                    if (idx == nv - K_WIDTH'(1)) begin
                        state_d = DRAIN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx + K_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (ph == PW'(L - 1)) begin
                        state_d = FIN;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph + PW'(1);
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        wgt_wen   = '0;
        pe_en     = 1'b0;
        in_valid  = '0;
        out_valid = '0;
        done      = 1'b0;
        busy      = (state != IDLE);
        in_idx    = idx;
        if (!hold) begin
            if (state == LOAD) begin
                wgt_wen = {{(ROWS-1){1'b0}}, 1'b1} << ph;
            end
            pe_en     = (state == STREAM) || (state == DRAIN);
            in_valid  = {sk[ROWS-2:0], streaming};
            out_valid = sk[L-1:ROWS-1];
            done      = (state == FIN);
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed checks for systolic_ctrl with ROWS=COLS=4, K_WIDTH=4.
// Expected values come from hand-written tables and the cycle schedule.
module tb_systolic_ctrl;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int KW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          hold;
    logic [KW-1:0] num_vec;
    logic [R-1:0]  wgt_wen;
    logic          pe_en;
    logic [R-1:0]  in_valid;
    logic [KW-1:0] in_idx;
    logic [C-1:0]  out_valid;
    logic          busy;
    logic          done;

    systolic_ctrl #(.ROWS(R), .COLS(C), .K_WIDTH(KW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_vec   (num_vec),
        .hold      (hold),
        .wgt_wen   (wgt_wen),
        .pe_en     (pe_en),
        .in_valid  (in_valid),
        .in_idx    (in_idx),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          st;
        logic [KW-1:0] nv;
        logic          hd;
        logic [R-1:0]  wgt;
        logic          pe;
        logic [R-1:0]  inv;
        logic [KW-1:0] idx;
        logic [C-1:0]  outv;
        logic          bsy;
        logic          dn;
    } vec_t;

    int passed = 0;
    int total  = 0;

    vec_t base[$];
    vec_t tv[$];

    function automatic vec_t mk(logic s, int n, logic h, logic [R-1:0] w,
                                logic p, logic [R-1:0] iv, int ix,
                                logic [C-1:0] ov, logic b, logic d);
        vec_t v;
        v.st = s; v.nv = KW'(n); v.hd = h;
        v.wgt = w; v.pe = p; v.inv = iv; v.idx = KW'(ix);
        v.outv = ov; v.bsy = b; v.dn = d;
        return v;
    endfunction

    function automatic vec_t zero_v();
        return mk(0, 0, 0, 4'b0, 0, 4'b0, 0, 4'b0, 0, 0);
    endfunction

    task automatic check(string name, int cyc, vec_t e);
        logic [18:0] act, exp;
        act = {wgt_wen, pe_en, in_valid, in_idx, out_valid, busy, done};
        exp = {e.wgt, e.pe, e.inv, e.idx, e.outv, e.bsy, e.dn};
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s cyc %0d: got wgt=%b pe=%b inv=%b idx=%0d outv=%b busy=%b done=%b, want wgt=%b pe=%b inv=%b idx=%0d outv=%b busy=%b done=%b",
                     name, cyc, wgt_wen, pe_en, in_valid, in_idx, out_valid,
                     busy, done, e.wgt, e.pe, e.inv, e.idx, e.outv,
                     e.bsy, e.dn);
        end
    endtask

    task automatic step(string name, int cyc, vec_t v);
        @(posedge clk);
        #1;
        start   = v.st;
        num_vec = v.nv;
        hold    = v.hd;
        @(negedge clk);
        check(name, cyc, v);
    endtask

    task automatic run_tv(string name);
        for (int i = 0; i < tv.size(); i++) begin
            step(name, i, tv[i]);
        end
    endtask

    // Schedule model for a long unheld run started in cycle 0.
    function automatic vec_t sched(int c, int n);
        vec_t v;
        int s;
        s = R + 1;
        v = zero_v();
        v.st = (c == 0);
        v.nv = (c == 0) ? KW'(n) : '0;
        if (c >= 1 && c <= R) v.wgt[c-1] = 1'b1;
        for (int r = 0; r < R; r++)
            v.inv[r] = (c - r >= s) && (c - r < s + n);
        for (int k = 0; k < C; k++)
            v.outv[k] = (c - R - k >= s) && (c - R - k < s + n);
        v.pe  = (c >= s) && (c < s + n + R + C - 1);
        v.idx = (c >= s && c < s + n) ? KW'(c - s) : '0;
        v.bsy = (c >= 1) && (c <= s + n + R + C - 1);
        v.dn  = (c == s + n + R + C - 1);
        return v;
    endfunction

    initial begin
        vec_t v;
        reset   = 1'b0;
        start   = 1'b0;
        hold    = 1'b0;
        num_vec = '0;

        base.push_back(mk(1, 3, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));
        base.push_back(mk(0, 0, 0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b0010, 0, 4'b0000, 0, 4'b0000, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b0100, 0, 4'b0000, 0, 4'b0000, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b1000, 0, 4'b0000, 0, 4'b0000, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0011, 1, 4'b0000, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0111, 2, 4'b0000, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b1110, 0, 4'b0000, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b1100, 0, 4'b0001, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b1000, 0, 4'b0011, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0111, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b1110, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b1100, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b1000, 1, 0));
        base.push_back(mk(0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 1, 1));
        base.push_back(mk(0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 0, zero_v());
        reset = 1'b1;

        // Basic run
        tv = base;
        run_tv("basic");

        // Hold in cycles 6-7: masked strobes, idx frozen, rest shifts +2
        tv.delete();
        for (int c = 0; c <= 18; c++) begin
            if (c < 6) begin
                v = base[c];
            end else if (c < 8) begin
                v = base[6];
                v.hd = 1'b1;
                v.wgt = '0; v.pe = 1'b0; v.inv = '0;
                v.outv = '0; v.dn = 1'b0;
            end else begin
                v = base[c-2];
            end
            tv.push_back(v);
        end
        run_tv("hold");

        // Zero count is ignored
        tv.delete();
        tv.push_back(mk(1, 0, 0, 4'b0, 0, 4'b0, 0, 4'b0, 0, 0));
        for (int c = 1; c <= 20; c++) tv.push_back(zero_v());
        run_tv("zero_cnt");

        // Starts while busy and on the done cycle are ignored
        tv = base;
        tv[6].st = 1'b1;  tv[6].nv = KW'(5);
        tv[15].st = 1'b1; tv[15].nv = KW'(5);
        tv.push_back(zero_v());
        tv.push_back(zero_v());
        run_tv("busy_start");

        // Reset during DRAIN clears outputs without a clock edge
        for (int c = 0; c < 10; c++) step("pre_reset", c, base[c]);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("reset_async", 10, zero_v());
        @(posedge clk);
        @(negedge clk);
        check("reset_held", 11, zero_v());
        reset = 1'b1;
        tv.delete();
        for (int c = 0; c < 3; c++) tv.push_back(zero_v());
        run_tv("post_reset_idle");

        // One-vector run after reset: done at cycle 2*4+4+1 = 13
        tv.delete();
        tv.push_back(mk(1, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0));
        tv.push_back(mk(0, 0, 0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 1, 0));
        tv.push_back(mk(0, 0, 0, 4'b0010, 0, 4'b0000, 0, 4'b0000, 1, 0));
        tv.push_back(mk(0, 0, 0, 4'b0100, 0, 4'b0000, 0, 4'b0000, 1, 0));
        tv.push_back(mk(0, 0, 0, 4'b1000, 0, 4'b0000, 0, 4'b0000, 1, 0));
        tv.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 1, 0));
        tv.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0010, 0, 4'b0000, 1, 0));
        tv.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 1, 0));
        tv.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b1000, 0, 4'b0000, 1, 0));
        tv.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0001, 1, 0));
        tv.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0010, 1, 0));
        tv.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0100, 1, 0));
        tv.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b1000, 1, 0));
        tv.push_back(mk(0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 1, 1));
        tv.push_back(zero_v());
        run_tv("one_vec");

        // Maximum count: 15 vectors, done at cycle 27
        tv.delete();
        for (int c = 0; c <= 29; c++) tv.push_back(sched(c, 15));
        run_tv("max_cnt");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
